// File: rtl/imm_pkg.sv
// Shared encodings for the immediate decode stage: immediate type codes
// and the RV base opcodes used to derive the type automatically.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_Z    = 3'd6,
      IMM_SH   = 3'd7
   } imm_type_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion: reassembles the immediate field of a
// 32-bit instruction for the given type and extends it to XLEN bits.
module imm_expand
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   input  logic [2:0]      type_i,
   output logic [XLEN-1:0] imm_o
);

   // The opcode field never contributes to an immediate.
   logic unused_opcode;
   assign unused_opcode = ^inst_i[6:0];

   // Field reassembly; signed casts carry inst[31] up to XLEN.
   always_comb begin
      imm_o = '0;
      case (type_i)
         IMM_I:   imm_o = XLEN'($signed(inst_i[31:20]));
         IMM_S:   imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
         IMM_B:   imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                         inst_i[11:8], 1'b0}));
         IMM_U:   imm_o = XLEN'($signed({inst_i[31:12], 12'h000}));
         IMM_J:   imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                         inst_i[30:21], 1'b0}));
         IMM_Z:   imm_o = XLEN'(inst_i[19:15]);
         IMM_SH:  imm_o = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: expands the immediate at acceptance and
// buffers results in a two-entry skid buffer (main + skid) with flush.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int TAG_W     = 32,
   parameter int AUTO_TYPE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_type,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_type,
   output logic [TAG_W-1:0] out_tag
);

   logic [2:0]       sel_type;
   logic [XLEN-1:0]  exp_imm;
   logic             accept;
   logic             drain;

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
   logic [2:0]       main_type_q, main_type_d, skid_type_q, skid_type_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;

   if (AUTO_TYPE != 0) begin : g_auto
      imm_type_e auto_type;
      logic      unused_type;
      assign unused_type = ^in_type;

      // Opcode/funct3 classification into an immediate type.
      always_comb begin
         auto_type = IMM_NONE;
         case (in_inst[6:0])
            OPC_LOAD, OPC_JALR: auto_type = IMM_I;
            OPC_OPIMM: auto_type = (in_inst[14:12] == F3_SLLI || in_inst[14:12] == F3_SRXI)
                                   ? IMM_SH : IMM_I;
            OPC_STORE:          auto_type = IMM_S;
            OPC_BRANCH:         auto_type = IMM_B;
            OPC_LUI, OPC_AUIPC: auto_type = IMM_U;
            OPC_JAL:            auto_type = IMM_J;
            OPC_SYSTEM:         auto_type = in_inst[14] ? IMM_Z : IMM_I;
            default:            auto_type = IMM_NONE;
         endcase
      end
      assign sel_type = auto_type;
   end else begin : g_manual
      assign sel_type = in_type;
   end

   imm_expand #(.XLEN(XLEN)) u_expand (
      .inst_i (in_inst),
      .type_i (sel_type),
      .imm_o  (exp_imm)
   );

   assign accept = in_valid & in_ready;
   assign drain  = main_valid_q & out_ready;

   // Skid-buffer next state; in_ready is low whenever skid holds an entry,
   // so a refill of main from skid never coincides with an acceptance.
   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_type_d  = main_type_q;
      main_tag_d   = main_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_type_d  = skid_type_q;
      skid_tag_d   = skid_tag_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || drain) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_type_d  = skid_type_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_imm_d   = exp_imm;
            main_type_d  = sel_type;
            main_tag_d   = in_tag;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = exp_imm;
         skid_type_d  = sel_type;
         skid_tag_d   = in_tag;
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_type_q  <= 3'd0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_type_q  <= 3'd0;
         skid_tag_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_type_q  <= main_type_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_type_q  <= skid_type_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_imm   = main_imm_q;
   assign out_type  = main_type_q;
   assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench: immediate vectors on three configurations,
// then skid-buffer backpressure, flush and asynchronous reset on the manual one.
module tb_imm_decode_stage;

   logic        clk       = 1'b0;
   logic        rst       = 1'b0;
   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_inst   = 32'h0;
   logic [2:0]  in_type   = 3'd0;
   logic [31:0] in_tag    = 32'h0;

   logic        m_in_ready, m_out_valid;
   logic [31:0] m_out_imm, m_out_tag;
   logic [2:0]  m_out_type;
   logic        a32_in_ready, a32_out_valid;
   logic [31:0] a32_out_imm, a32_out_tag;
   logic [2:0]  a32_out_type;
   logic        a64_in_ready, a64_out_valid;
   logic [63:0] a64_out_imm;
   logic [31:0] a64_out_tag;
   logic [2:0]  a64_out_type;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .TAG_W(32), .AUTO_TYPE(0)) u_man (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
      .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(m_out_valid),
      .out_ready(out_ready), .out_imm(m_out_imm), .out_type(m_out_type), .out_tag(m_out_tag));

   imm_decode_stage #(.XLEN(32), .TAG_W(32), .AUTO_TYPE(1)) u_a32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a32_in_ready),
      .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(a32_out_valid),
      .out_ready(out_ready), .out_imm(a32_out_imm), .out_type(a32_out_type), .out_tag(a32_out_tag));

   imm_decode_stage #(.XLEN(64), .TAG_W(32), .AUTO_TYPE(1)) u_a64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a64_in_ready),
      .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(a64_out_valid),
      .out_ready(out_ready), .out_imm(a64_out_imm), .out_type(a64_out_type), .out_tag(a64_out_tag));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full-throughput vector through all three configurations.
   task automatic vec(input string name, input logic [31:0] inst, input logic [2:0] mtype,
                      input logic [31:0] mimm, input logic [2:0] atype,
                      input logic [31:0] a32imm, input logic [63:0] a64imm);
      in_valid  = 1'b1;
      in_inst   = inst;
      in_type   = mtype;
      in_tag    = inst;
      out_ready = 1'b1;
      flush     = 1'b0;
      @(negedge clk);
      check({name, ".m_valid"}, {63'd0, m_out_valid}, 64'd1);
      check({name, ".m_imm"},   {32'd0, m_out_imm}, {32'd0, mimm});
      check({name, ".m_type"},  {61'd0, m_out_type}, {61'd0, mtype});
      check({name, ".m_tag"},   {32'd0, m_out_tag}, {32'd0, inst});
      check({name, ".a32_imm"}, {32'd0, a32_out_imm}, {32'd0, a32imm});
      check({name, ".a32_type"}, {61'd0, a32_out_type}, {61'd0, atype});
      check({name, ".a64_imm"}, a64_out_imm, a64imm);
      check({name, ".a64_type"}, {61'd0, a64_out_type}, {61'd0, atype});
   endtask

   // One handshake cycle on the manual instance; tag doubles as an I-type immediate.
   task automatic cyc(input string name, input logic iv, input logic [31:0] tag,
                      input logic ordy, input logic fl, input logic eov,
                      input logic [31:0] etag, input logic erdy);
      in_valid  = iv;
      in_tag    = tag;
      in_inst   = {tag[11:0], 20'h00013};
      in_type   = 3'd1;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      check({name, ".valid"}, {63'd0, m_out_valid}, {63'd0, eov});
      check({name, ".ready"}, {63'd0, m_in_ready}, {63'd0, erdy});
      if (eov) begin
         check({name, ".tag"}, {32'd0, m_out_tag}, {32'd0, etag});
         check({name, ".imm"}, {32'd0, m_out_imm}, {32'd0, etag});
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      check("rst.valid", {63'd0, m_out_valid}, 64'd0);
      check("rst.ready", {63'd0, m_in_ready}, 64'd1);
      check("rst.imm",   {32'd0, m_out_imm}, 64'd0);
      check("rst.type",  {61'd0, m_out_type}, 64'd0);
      check("rst.tag",   {32'd0, m_out_tag}, 64'd0);
      check("rst.a64imm", a64_out_imm, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      vec("addi_m1", 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      vec("sw_m4",   32'hFE112E23, 3'd2, 32'hFFFFFFFC, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
      vec("beq_m4",  32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
      vec("lui_neg", 32'h800000B7, 3'd4, 32'h80000000, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000);
      vec("jal_m8",  32'hFF9FF06F, 3'd5, 32'hFFFFFFF8, 3'd5, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
      vec("csrrwi",  32'h300FD073, 3'd6, 32'h0000001F, 3'd6, 32'h0000001F, 64'h000000000000001F);
      vec("slli63",  32'h03F09093, 3'd7, 32'h0000001F, 3'd7, 32'h0000001F, 64'h000000000000003F);
      vec("add",     32'h002081B3, 3'd0, 32'h00000000, 3'd0, 32'h00000000, 64'h0000000000000000);
      vec("csrrw",   32'h30001073, 3'd1, 32'h00000300, 3'd1, 32'h00000300, 64'h0000000000000300);
      vec("srai3",   32'h4030D093, 3'd3, 32'h00000C00, 3'd7, 32'h00000003, 64'h0000000000000003);
      vec("lw_m1",   32'hFFF12083, 3'd4, 32'hFFF12000, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      vec("auipc",   32'h00001097, 3'd2, 32'h00000001, 3'd4, 32'h00001000, 64'h0000000000001000);

      // Idle inputs with in_valid low must not create an entry.
      in_valid = 1'b0;
      in_inst  = 32'hFFFFFFFF;
      in_type  = 3'd7;
      @(negedge clk);
      check("idle.valid", {63'd0, m_out_valid}, 64'd0);
      check("idle.ready", {63'd0, m_in_ready}, 64'd1);

      // Backpressure: three stalled cycles, then drain in order without gaps.
      cyc("bp0", 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b1);
      cyc("bp1", 1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0);
      cyc("bp2", 1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0);
      cyc("bp3", 1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 32'd2, 1'b1);
      cyc("bp4", 1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 32'd3, 1'b1);
      cyc("bp5", 1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 32'd4, 1'b1);
      cyc("bp6", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

      // Flush with both entries full, then flush against a live acceptance.
      cyc("fl0", 1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 32'd10, 1'b1);
      cyc("fl1", 1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
      cyc("fl2", 1'b1, 32'd12, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1);
      cyc("fl3", 1'b1, 32'd13, 1'b1, 1'b0, 1'b1, 32'd13, 1'b1);
      cyc("fl4", 1'b1, 32'd14, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1);
      cyc("fl5", 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  1'b1);

      // Asynchronous reset with both entries occupied.
      cyc("rs0", 1'b1, 32'd15, 1'b0, 1'b0, 1'b1, 32'd15, 1'b1);
      cyc("rs1", 1'b1, 32'd16, 1'b0, 1'b0, 1'b1, 32'd15, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst.valid", {63'd0, m_out_valid}, 64'd0);
      check("mid_rst.ready", {63'd0, m_in_ready}, 64'd1);
      check("mid_rst.imm",   {32'd0, m_out_imm}, 64'd0);
      check("mid_rst.type",  {61'd0, m_out_type}, 64'd0);
      check("mid_rst.tag",   {32'd0, m_out_tag}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc("rs2", 1'b1, 32'd17, 1'b1, 1'b0, 1'b1, 32'd17, 1'b1);
      cyc("rs3", 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
